// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids and
// the word-address legality check used at grant time.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // A word access is illegal when misaligned or when its last byte would fall
  // past the end of the memory (legal range 0 .. height-4).
  function automatic logic addr_illegal(input logic [63:0] addr,
                                        input logic [63:0] height);
    return (addr[1:0] != 2'b00) || (addr > height - 64'd4);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and DATA_MEMORY pins around dmem_arbiter.
//
// Handshake: a requester raises req with we/addr/wd and holds all four stable
// until it sees gnt high at a rising edge; that edge latches the request and
// the requester may then drop or change them. Exactly two cycles after the
// grant cycle, done pulses for one cycle with rdata/err valid only during it.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wd0;
  logic [DATA_W-1:0] i_wd1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_done0;
  logic              o_done1;
  logic [DATA_W-1:0] o_rdata0;
  logic [DATA_W-1:0] o_rdata1;
  logic              o_err0;
  logic              o_err1;
  logic [ADDR_W-1:0] o_mem_Addr;
  logic [DATA_W-1:0] o_mem_Wd;
  logic              o_mem_Wen;
  logic              o_mem_Ren;
  logic [DATA_W-1:0] i_mem_Rd;

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wd0, i_wd1,
    input  o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    input  o_err0, o_err1
  );

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wd0, i_wd1,
    output o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    output o_err0, o_err1,
    output o_mem_Addr, o_mem_Wd, o_mem_Wen, o_mem_Ren,
    input  i_mem_Rd
  );

  modport memory (
    input  o_mem_Addr, o_mem_Wd, o_mem_Wen, o_mem_Ren,
    output i_mem_Rd
  );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Two-requester grant picker returning a one-hot grant {port1, port0}.
// DMEM_ARB_RR_EN selects round-robin (prio names the tie winner); otherwise port 0 wins ties.
module dmem_rr_picker
  import dmem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
`ifdef DMEM_ARB_RR_EN
  input  logic       prio,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) begin
      gnt = (prio == PORT_DMA) ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
`else
    if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one DATA_MEMORY port between the LSU (port 0) and the loader/DMA (port 1):
// IDLE/RESP grant -> ACCESS -> RESP. Round-robin ties when DMEM_ARB_RR_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int HEIGHT = 256
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  dmem_arbiter_if.slave bus,
  output state_t       dbg_state
);

  state_t            state;
  state_t            state_nxt;

  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              grant_any;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_err;

  logic              lat_id;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              mem_wen_q;
  logic              mem_ren_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done0;
  logic              done1;

`ifdef DMEM_ARB_RR_EN
  logic              prio_q;

  dmem_rr_picker u_picker (
    .req0 (bus.i_req0),
    .req1 (bus.i_req1),
    .prio (prio_q),
    .gnt  (pick)
  );
`else
  dmem_rr_picker u_picker (
    .req0 (bus.i_req0),
    .req1 (bus.i_req1),
    .gnt  (pick)
  );
`endif

  // Grants are combinational, so they must also vanish while reset is held.
  always_comb begin
    gnt       = 2'b00;
    if (i_rst_n && (state != ACCESS)) begin
      gnt = pick;
    end
    grant_any = |gnt;
    grant_id  = gnt[1];
    sel_we    = grant_id ? bus.i_we1   : bus.i_we0;
    sel_addr  = grant_id ? bus.i_addr1 : bus.i_addr0;
    sel_wd    = grant_id ? bus.i_wd1   : bus.i_wd0;
    sel_err   = addr_illegal(64'(sel_addr), 64'(HEIGHT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = grant_any ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The memory pin registers double as the latched request: loaded at the
  // grant edge, strobes held for the single ACCESS cycle only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_id     <= PORT_LSU;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
    end else if (grant_any) begin
      lat_id     <= grant_id;
      lat_we     <= sel_we;
      lat_err    <= sel_err;
      mem_addr_q <= sel_addr;
      mem_wd_q   <= sel_wd;
      mem_wen_q  <= sel_we & ~sel_err;
      mem_ren_q  <= ~sel_we & ~sel_err;
    end else begin
      mem_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= (lat_we || lat_err) ? '0 : bus.i_mem_Rd;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // After any grant the other port owns the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_q <= PORT_LSU;
    end else if (grant_any) begin
      prio_q <= ~grant_id;
    end
  end
`endif

  always_comb begin
    done0 = (state == RESP) && (lat_id == PORT_LSU);
    done1 = (state == RESP) && (lat_id == PORT_DMA);
  end

  assign bus.o_gnt0     = gnt[0];
  assign bus.o_gnt1     = gnt[1];
  assign bus.o_done0    = done0;
  assign bus.o_done1    = done1;
  assign bus.o_rdata0   = done0 ? rdata_q : '0;
  assign bus.o_rdata1   = done1 ? rdata_q : '0;
  assign bus.o_err0     = done0 & lat_err;
  assign bus.o_err1     = done1 & lat_err;
  assign bus.o_mem_Addr = mem_addr_q;
  assign bus.o_mem_Wd   = mem_wd_q;
  assign bus.o_mem_Wen  = mem_wen_q;
  assign bus.o_mem_Ren  = mem_ren_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a word-array memory model;
// the arbitration rule follows DMEM_ARB_RR_EN in the same way as the design.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int HEIGHT = 256;
  localparam int WORDS  = HEIGHT / 4;

  typedef struct {
    logic        id;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gcyc;
  } exp_t;

  logic   i_clk;
  logic   i_rst_n;
  state_t dbg_state;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HEIGHT(HEIGHT)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- DATA_MEMORY model ----------------
  logic [31:0] mem_arr [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];

  always @(posedge i_clk) begin
    if (bus.o_mem_Wen) mem_arr[bus.o_mem_Addr[7:2]] <= bus.o_mem_Wd;
  end
  assign bus.i_mem_Rd = bus.o_mem_Ren ? mem_arr[bus.o_mem_Addr[7:2]] : '0;

  // ---------------- scoreboard ----------------
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t lastg;
  exp_t e;
  int   last_gcyc = -100;
  logic rr_prio   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic ref_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a > HEIGHT - 4);
  endfunction

  // Monitor: response check, strobe check, then grant check with scoreboard push.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      logic [1:0] exp_g;
      logic       exp_wen;
      logic       exp_ren;
      logic       rq0;
      logic       rq1;
      if (bus.o_done0 || bus.o_done1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {bus.o_done1, bus.o_done0}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("done_port", {bus.o_done1, bus.o_done0}, e.id ? 2'b10 : 2'b01);
          chk("done_latency", cyc - e.gcyc, 2);
          chk("rdata", e.id ? bus.o_rdata1 : bus.o_rdata0, e.rdata);
          chk("err", e.id ? bus.o_err1 : bus.o_err0, e.err);
          if (!e.err && e.we) ref_mem[e.addr[7:2]] = e.wd;
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].gcyc + 2) begin
        chk("missing_done", 0, 1);
        void'(exp_q.pop_front());
      end
      if (!bus.o_done0) chk("rdata0_gated", {bus.o_err0, bus.o_rdata0}, 0);
      if (!bus.o_done1) chk("rdata1_gated", {bus.o_err1, bus.o_rdata1}, 0);

      exp_wen = (cyc == last_gcyc + 1) && !lastg.err && lastg.we;
      exp_ren = (cyc == last_gcyc + 1) && !lastg.err && !lastg.we;
      chk("mem_strobes", {bus.o_mem_Wen, bus.o_mem_Ren}, {exp_wen, exp_ren});
      if (exp_wen || exp_ren) chk("mem_addr", bus.o_mem_Addr, lastg.addr);
      if (exp_wen) chk("mem_wd", bus.o_mem_Wd, lastg.wd);

      // A grant slot exists in every cycle except the one right after a grant.
      rq0   = bus.i_req0;
      rq1   = bus.i_req1;
      exp_g = 2'b00;
      if (cyc != last_gcyc + 1) begin
        if (rq0 && rq1) begin
`ifdef DMEM_ARB_RR_EN
          exp_g = rr_prio ? 2'b10 : 2'b01;
`else
          exp_g = 2'b01;
`endif
        end else if (rq0) begin
          exp_g = 2'b01;
        end else if (rq1) begin
          exp_g = 2'b10;
        end
      end
      chk("grant", {bus.o_gnt1, bus.o_gnt0}, exp_g);
      if (exp_g != 2'b00) begin
        lastg.id    = exp_g[1];
        lastg.we    = exp_g[1] ? bus.i_we1   : bus.i_we0;
        lastg.addr  = exp_g[1] ? bus.i_addr1 : bus.i_addr0;
        lastg.wd    = exp_g[1] ? bus.i_wd1   : bus.i_wd0;
        lastg.err   = ref_illegal(lastg.addr);
        lastg.rdata = (lastg.err || lastg.we) ? 32'h0 : ref_mem[lastg.addr[7:2]];
        lastg.gcyc  = cyc;
        exp_q.push_back(lastg);
        last_gcyc = cyc;
        rr_prio   = ~exp_g[1];
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (port == 1'b0) begin
      bus.i_req0 = req; bus.i_we0 = we; bus.i_addr0 = addr; bus.i_wd0 = wd;
    end else begin
      bus.i_req1 = req; bus.i_we1 = we; bus.i_addr1 = addr; bus.i_wd1 = wd;
    end
  endtask

  // Called just after a rising edge; returns just after the grant edge.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd);
    bit got = 1'b0;
    set_port(port, 1'b1, we, addr, wd);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge i_clk);
      got = port ? bus.o_gnt1 : bus.o_gnt0;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    @(posedge i_clk);
    #1;
    set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, WORDS - 1) * 4);
    else if (r == 7) return 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
    else if (r == 8) return 32'($urandom_range(WORDS, 4 * WORDS - 1) * 4);
    else             return $urandom;
  endfunction

  task automatic rand_stream(input bit port, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      do_access(port, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          start_cyc;
    logic [31:0] tmp;
    logic [31:0] b2b_data [0:WORDS-1];

    for (int i = 0; i < WORDS; i++) begin
      tmp = $urandom;
      mem_arr[i] <= tmp;
      ref_mem[i]  = tmp;
    end
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    i_rst_n = 1'b0;
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_strobes", {bus.o_mem_Wen, bus.o_mem_Ren}, 0);
    chk("rst_mem_addr", bus.o_mem_Addr, 0);
    chk("rst_mem_wd", bus.o_mem_Wd, 0);
    chk("rst_done", {bus.o_gnt1, bus.o_gnt0, bus.o_done1, bus.o_done0, bus.o_err1, bus.o_err0}, 0);
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    idle_cycles(2);

    // Port 0 write then read of the same word.
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1'b0, 1'b0, 32'h10, 32'h0);
    idle_cycles(3);

    // Both ports hold requests to word 0.
    fork
      for (int i = 0; i < 4; i++) do_access(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) do_access(1'b1, 1'b0, 32'h0, 32'h0);
    join
    idle_cycles(3);

    // Illegal accesses.
    do_access(1'b0, 1'b0, 32'h12, 32'h0);
    do_access(1'b1, 1'b0, 32'h100, 32'h0);
    do_access(1'b0, 1'b1, 32'h102, 32'hCAFEF00D);
    do_access(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0BAD0BAD);
    idle_cycles(3);

    // Back-to-back fill and read-back from port 1: one access per two cycles.
    start_cyc = cyc;
    for (int i = 0; i < WORDS; i++) begin
      b2b_data[i] = $urandom;
      do_access(1'b1, 1'b1, 32'(i * 4), b2b_data[i]);
    end
    for (int i = 0; i < WORDS; i++) do_access(1'b1, 1'b0, 32'(i * 4), 32'h0);
    chk("b2b_span", cyc - start_cyc, 2 * (2 * WORDS - 1) + 1);
    idle_cycles(3);
    chk("b2b_last_word", ref_mem[WORDS-1], b2b_data[WORDS-1]);

    // Random traffic from both ports.
    fork
      rand_stream(1'b0, 25);
      rand_stream(1'b1, 25);
    join
    idle_cycles(4);

    // Reset during the ACCESS cycle of a write: nothing commits, no done.
    set_port(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    for (int i = 0; i < 20 && !bus.o_gnt0; i++) @(negedge i_clk);
    chk("abort_gnt", bus.o_gnt0, 1);
    @(posedge i_clk);
    #2;
    chk("abort_wen_before", bus.o_mem_Wen, 1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_state", dbg_state, IDLE);
    chk("abort_strobes", {bus.o_mem_Wen, bus.o_mem_Ren}, 0);
    chk("abort_mem_addr", bus.o_mem_Addr, 0);
    chk("abort_mem_wd", bus.o_mem_Wd, 0);
    chk("abort_outs", {bus.o_gnt1, bus.o_gnt0, bus.o_done1, bus.o_done0, bus.o_err1, bus.o_err0}, 0);
    chk("abort_rdata", bus.o_rdata0 | bus.o_rdata1, 0);
    exp_q.delete();
    last_gcyc = -100;
    rr_prio   = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge i_clk);
    chk("abort_no_done", {bus.o_done1, bus.o_done0}, 0);
    #2 i_rst_n = 1'b1;
    idle_cycles(1);
    do_access(1'b0, 1'b0, 32'h20, 32'h0);
    idle_cycles(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of `DATA_MEMORY`. It shares the single data-memory port between requester 0 (core load/store unit) and requester 1 (loader/DMA). Each requester uses a request/grant/done handshake. The block drives the memory's address, write-data and enable pins from registers, captures read data, and rejects misaligned or out-of-range word accesses.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: byte-address width.
- `HEIGHT`, 256: memory size in bytes; legal addresses are `0 .. HEIGHT-4`.
- `i_clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_req0`, `i_req1`  in  1: access request, held until granted.
- `i_we0`, `i_we1`  in  1: 1 = write, 0 = read.
- `i_addr0`, `i_addr1`  in  ADDR_W: byte address.
- `i_wd0`, `i_wd1`  in  DATA_W: write data.
- `o_gnt0`, `o_gnt1`  out  1: combinational grant; the request is latched at this edge.
- `o_done0`, `o_done1`  out  1: one-cycle completion pulse.
- `o_rdata0`, `o_rdata1`  out  DATA_W: read data, valid while done is high.
- `o_err0`, `o_err1`  out  1: error flag, valid while done is high.
- `o_mem_Addr`  out  ADDR_W: to `DATA_MEMORY.i_Addr`.
- `o_mem_Wd`  out  DATA_W: to `i_Wd`.
- `o_mem_Wen`, `o_mem_Ren`  out  1: to `i_Wen` / `i_Ren`.
- `i_mem_Rd`  in  DATA_W: from `o_Rd`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: any request present → grant one, latch `{we, addr, wd, id}`, go to ACCESS. No request → stay.
  - ACCESS: drive the memory from the latched registers. Write commits at the closing edge. Read data is sampled into the rdata register at the same edge. Go to RESP.
  - RESP: pulse `o_done<id>` and present `o_rdata<id>`/`o_err<id>`. The grant logic is active here as in IDLE: a new request is granted and goes to ACCESS, otherwise go to IDLE.
- Error check at grant: `addr[1:0] != 0` or `addr > HEIGHT-4`.
  - The access is marked error.
  - ACCESS drives `o_mem_Wen = o_mem_Ren = 0`.
  - RESP gives done with err=1 and rdata=0.
- `o_rdata` is 0 for writes. The rdata register holds its value outside RESP, but `o_rdata<k>` is gated to 0 unless done<k> is high.
- Only one grant per cycle. `o_gnt<k>` is never high in ACCESS.
- Reset values: state IDLE; all `o_gnt`/`o_done`/`o_err` = 0; `o_rdata` = 0; `o_mem_Addr`, `o_mem_Wd` = 0; `o_mem_Wen`, `o_mem_Ren` = 0; priority pointer = port 0.
- Reset asserted mid-operation: all outputs go to reset values immediately, asynchronously. A pending write not yet at its commit edge is dropped. No done is issued for the aborted access.

## Timing
- Cycle N: request seen in IDLE or RESP → gnt high in N.
- Cycle N+1: memory strobes active.
- Cycle N+2: done.
- Latency: 2 cycles from grant to done.
- Back-to-back throughput: one access per 2 cycles.
- Memory pins are registered outputs; they change only on `i_clk` edges or on reset.
- A requester must hold `req`, `we`, `addr` and `wd` stable until its gnt edge. It may drop or change them after that.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. When both ports request, grant the port not granted last. The pointer updates on every grant, so port 0 wins the first tie after reset.
- `DMEM_ARB_RR_EN` undefined: fixed priority; port 0 always wins ties. Pointer logic is absent.

## Structure
- Shared package/header holds:
  - state encodings: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - port-id constants: `PORT_LSU=0`, `PORT_DMA=1`;
  - the address-check helper.
- One sub-module, `dmem_rr_picker`: takes req0/req1 and the last-grant pointer, returns a one-hot grant. The fixed-priority variant is built inside it under the macro.

## Test plan
- Port 0 writes `0xDEADBEEF` to 0x10, then reads 0x10 → gnt0 in the request cycle; done0 two cycles later with rdata0=`0xDEADBEEF`, err0=0.
- req0 and req1 both high with RR enabled, both reading 0x0 and both held until granted → gnt0 first, then gnt1 in the RESP cycle. Grants alternate over 8 held cycles. With the macro undefined and req0 held, port 1 is never granted.
- Read at 0x12 (misaligned) and at 0x100 with HEIGHT=256 → each gives done with err=1 and rdata=0. `o_mem_Wen`/`o_mem_Ren` stay 0 throughout.
- Back-to-back writes from port 1 to 0x0, 0x4, 0x8, … up to 0xFC, then read-back of all 64 words → one done per 2 cycles; every word matches.
- `i_rst_n` pulsed low during the ACCESS cycle of a write of `0x12345678` to 0x20 → all outputs 0 immediately; no done; a subsequent read of 0x20 returns the old contents.
